// File: rtl/trap_pkg.sv
// trap_pkg: types and constants shared by the trap sequencer.
//   trap_state_e : sequencer state encoding (also exported on the debug port)
//   CAUSE_*      : mcause code values for the handled exceptions/interrupts
//   CAUSE_W_DEF  : default cause-code width (mcause code field)
package trap_pkg;

  localparam int CAUSE_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_TAKE    = 2'd2,
    ST_HANDLER = 2'd3
  } trap_state_e;

  // Synchronous exception codes
  localparam int CAUSE_ILLEGAL = 2;
  localparam int CAUSE_EBREAK  = 3;
  localparam int CAUSE_ECALL_M = 11;

  // Machine interrupt codes
  localparam int CAUSE_MSI = 3;
  localparam int CAUSE_MTI = 7;
  localparam int CAUSE_MEI = 11;

endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: combinational priority encoder for trap causes.
//   Inputs : exception requests (illegal, ebreak, ecall) and already-gated
//            interrupt requests (external, software, timer).
//   Outputs: any    - some request is present
//            is_int - the winning request is an interrupt
//            cause  - mcause code of the winner
//   Any exception beats any interrupt.
//   Exceptions  : illegal > ebreak > ecall.
//   Interrupts  : external > software > timer.
module trap_prio_enc
  import trap_pkg::*;
#(
  parameter int CAUSE_W = CAUSE_W_DEF
) (
  input  logic               exc_illegal,
  input  logic               exc_ebreak,
  input  logic               exc_ecall,
  input  logic               int_mei,
  input  logic               int_msi,
  input  logic               int_mti,
  output logic               any,
  output logic               is_int,
  output logic [CAUSE_W-1:0] cause
);

  always_comb begin
    any    = 1'b1;
    is_int = 1'b0;
    cause  = '0;
    if (exc_illegal) begin
      cause = CAUSE_W'(CAUSE_ILLEGAL);
    end else if (exc_ebreak) begin
      cause = CAUSE_W'(CAUSE_EBREAK);
    end else if (exc_ecall) begin
      cause = CAUSE_W'(CAUSE_ECALL_M);
    end else if (int_mei) begin
      is_int = 1'b1;
      cause  = CAUSE_W'(CAUSE_MEI);
    end else if (int_msi) begin
      is_int = 1'b1;
      cause  = CAUSE_W'(CAUSE_MSI);
    end else if (int_mti) begin
      is_int = 1'b1;
      cause  = CAUSE_W'(CAUSE_MTI);
    end else begin
      any = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer in front of the CSR array.
//   Arbitrates EX-stage exceptions against gated machine interrupts, waits
//   for the pipeline's PC-state window before taking an interrupt, issues a
//   one-cycle trap_take strobe with a held cause, and tracks handler
//   residency until mret.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   g_interrupt/frc_cntr_val_leq/
//   sw_interrupt                    level interrupt sources
//   csr_rmie/meie/mtie/msie         mstatus.MIE and mie enables
//   illegal_ops_ex/cmd_ecall_ex/
//   cmd_ebreak_ex/cmd_mret_ex       EX-stage instruction events
//   cpu_stat_before_exec            pipeline in PC state (interrupt window)
//   trap_take                       one-cycle trap entry strobe
//   trap_is_int, trap_cause         latched cause, changes only entering TAKE
//   in_handler                      trap taken, mret not yet executed
//   drain_req                       ARMED too long, pipeline asked to drain
//   double_fault                    sticky fault flag (TRAP_DOUBLE_FAULT_EN)
//   dbg_state                       current sequencer state
// Optional feature macro: TRAP_DOUBLE_FAULT_EN. When defined, an exception
// inside the handler sets a sticky double_fault and all further traps are
// ignored until reset; otherwise it re-enters TAKE and double_fault is 0.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int CAUSE_W = CAUSE_W_DEF,
  parameter int ARM_TMO = 16,
  parameter int TMO_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               g_interrupt,
  input  logic               frc_cntr_val_leq,
  input  logic               sw_interrupt,
  input  logic               csr_rmie,
  input  logic               csr_meie,
  input  logic               csr_mtie,
  input  logic               csr_msie,
  input  logic               illegal_ops_ex,
  input  logic               cmd_ecall_ex,
  input  logic               cmd_ebreak_ex,
  input  logic               cmd_mret_ex,
  input  logic               cpu_stat_before_exec,
  output logic               trap_take,
  output logic               trap_is_int,
  output logic [CAUSE_W-1:0] trap_cause,
  output logic               in_handler,
  output logic               drain_req,
  output logic               double_fault,
  output trap_state_e        dbg_state
);

  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(ARM_TMO);

  trap_state_e        state_q, state_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               is_int_q, is_int_d;
  logic               drain_q, drain_d;
  logic               df_active;

  logic               int_mei, int_msi, int_mti;
  logic               exc, int_ok, exc_g, int_g;
  logic               enc_any, enc_is_int;
  logic [CAUSE_W-1:0] enc_cause;

  assign int_mei = csr_rmie & g_interrupt      & csr_meie;
  assign int_msi = csr_rmie & sw_interrupt     & csr_msie;
  assign int_mti = csr_rmie & frc_cntr_val_leq & csr_mtie;
  assign int_ok  = int_mei | int_msi | int_mti;
  assign exc     = illegal_ops_ex | cmd_ecall_ex | cmd_ebreak_ex;

  // A latched double fault silences every trap source.
  assign exc_g = exc    & ~df_active;
  assign int_g = int_ok & ~df_active;

  trap_prio_enc #(.CAUSE_W(CAUSE_W)) u_prio (
    .exc_illegal (illegal_ops_ex),
    .exc_ebreak  (cmd_ebreak_ex),
    .exc_ecall   (cmd_ecall_ex),
    .int_mei     (int_mei),
    .int_msi     (int_msi),
    .int_mti     (int_mti),
    .any         (enc_any),
    .is_int      (enc_is_int),
    .cause       (enc_cause)
  );

`ifdef TRAP_DOUBLE_FAULT_EN
  logic df_q, df_d;
  assign df_active = df_q;
`else
  assign df_active = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    is_int_d = is_int_q;
`ifdef TRAP_DOUBLE_FAULT_EN
    df_d     = df_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (exc_g) begin
          state_d = ST_TAKE;
        end else if (int_g) begin
          state_d = ST_ARMED;
          cnt_d   = '0;
        end
      end
      ST_ARMED: begin
        if (exc_g) begin
          state_d = ST_TAKE;
        end else if (!int_g) begin
          state_d = ST_IDLE;
        end else if (cpu_stat_before_exec) begin
          state_d = ST_TAKE;
        end else if (cnt_q != TMO_MAX) begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      ST_TAKE: begin
        state_d = ST_HANDLER;
      end
      ST_HANDLER: begin
        // Interrupts are not considered here; only exceptions and mret.
        if (exc_g) begin
`ifdef TRAP_DOUBLE_FAULT_EN
          df_d    = 1'b1;
          state_d = ST_IDLE;
`else
          state_d = ST_TAKE;
`endif
        end else if (cmd_mret_ex) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Cause is captured only on entry to TAKE; the encoder already gives
    // exceptions precedence, and in ARMED-with-window no exception exists.
    if (state_d == ST_TAKE && state_q != ST_TAKE && enc_any) begin
      cause_d  = enc_cause;
      is_int_d = enc_is_int;
    end

    drain_d = (state_d == ST_ARMED) && (cnt_d == TMO_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cause_q  <= '0;
      is_int_q <= 1'b0;
      drain_q  <= 1'b0;
`ifdef TRAP_DOUBLE_FAULT_EN
      df_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      is_int_q <= is_int_d;
      drain_q  <= drain_d;
`ifdef TRAP_DOUBLE_FAULT_EN
      df_q     <= df_d;
`endif
    end
  end

  assign trap_take    = (state_q == ST_TAKE);
  assign in_handler   = (state_q == ST_HANDLER);
  assign trap_cause   = cause_q;
  assign trap_is_int  = is_int_q;
  assign drain_req    = drain_q;
  assign double_fault = df_active;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed bench for trap_ctrl. Inputs change 1 time unit
// after a rising edge; outputs are checked at that same point, so every
// check sees the state produced by the edge just taken.
module tb_trap_ctrl;

  logic       clk;
  logic       rst_n;
  logic       g_interrupt, frc_cntr_val_leq, sw_interrupt;
  logic       csr_rmie, csr_meie, csr_mtie, csr_msie;
  logic       illegal_ops_ex, cmd_ecall_ex, cmd_ebreak_ex, cmd_mret_ex;
  logic       cpu_stat_before_exec;
  logic       trap_take, trap_is_int, in_handler, drain_req, double_fault;
  logic [5:0] trap_cause;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  trap_ctrl #(.CAUSE_W(6), .ARM_TMO(16), .TMO_W(8)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .g_interrupt          (g_interrupt),
    .frc_cntr_val_leq     (frc_cntr_val_leq),
    .sw_interrupt         (sw_interrupt),
    .csr_rmie             (csr_rmie),
    .csr_meie             (csr_meie),
    .csr_mtie             (csr_mtie),
    .csr_msie             (csr_msie),
    .illegal_ops_ex       (illegal_ops_ex),
    .cmd_ecall_ex         (cmd_ecall_ex),
    .cmd_ebreak_ex        (cmd_ebreak_ex),
    .cmd_mret_ex          (cmd_mret_ex),
    .cpu_stat_before_exec (cpu_stat_before_exec),
    .trap_take            (trap_take),
    .trap_is_int          (trap_is_int),
    .trap_cause           (trap_cause),
    .in_handler           (in_handler),
    .drain_req            (drain_req),
    .double_fault         (double_fault),
    .dbg_state            (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    g_interrupt = 0; frc_cntr_val_leq = 0; sw_interrupt = 0;
    csr_rmie = 0; csr_meie = 0; csr_mtie = 0; csr_msie = 0;
    illegal_ops_ex = 0; cmd_ecall_ex = 0; cmd_ebreak_ex = 0; cmd_mret_ex = 0;
    cpu_stat_before_exec = 0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;

    // ---- reset state
    tick(); tick();
    check("rst_take",   32'(trap_take),    0);
    check("rst_inh",    32'(in_handler),   0);
    check("rst_cause",  32'(trap_cause),   0);
    check("rst_isint",  32'(trap_is_int),  0);
    check("rst_drain",  32'(drain_req),    0);
    check("rst_df",     32'(double_fault), 0);
    check("rst_state",  32'(dbg_state),    0);
    rst_n = 1;
    tick();

    // ---- exception path: illegal for one cycle
    illegal_ops_ex = 1;
    tick();
    check("exc_take",   32'(trap_take),   1);
    check("exc_cause",  32'(trap_cause),  2);
    check("exc_isint",  32'(trap_is_int), 0);
    illegal_ops_ex = 0;
    tick();
    check("exc_take_off", 32'(trap_take),  0);
    check("exc_inh",      32'(in_handler), 1);
    check("exc_hold",     32'(trap_cause), 2);
    cmd_mret_ex = 1;
    tick();
    cmd_mret_ex = 0;
    check("mret_inh",   32'(in_handler), 0);
    check("mret_state", 32'(dbg_state),  0);

    // ---- interrupt arbitration: external beats timer, window after 5 cycles
    csr_rmie = 1; csr_meie = 1; csr_mtie = 1;
    g_interrupt = 1; frc_cntr_val_leq = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("arb_wait_take",  32'(trap_take), 0);
      check("arb_wait_state", 32'(dbg_state), 1);
    end
    cpu_stat_before_exec = 1;
    tick();
    check("arb_take",  32'(trap_take),   1);
    check("arb_cause", 32'(trap_cause),  11);
    check("arb_isint", 32'(trap_is_int), 1);
    // interrupts stay pending: handler must ignore them
    tick();
    check("arb_inh", 32'(in_handler), 1);
    tick();
    check("hnd_ignore_int_take",  32'(trap_take), 0);
    check("hnd_ignore_int_state", 32'(dbg_state), 3);
    clear_inputs();
    cmd_mret_ex = 1;
    tick();
    cmd_mret_ex = 0;
    check("arb_mret_state", 32'(dbg_state), 0);

    // ---- software beats timer, minimum latency with window already open
    csr_rmie = 1; csr_msie = 1; csr_mtie = 1;
    sw_interrupt = 1; frc_cntr_val_leq = 1; cpu_stat_before_exec = 1;
    tick();
    check("sw_armed_take", 32'(trap_take), 0);
    tick();
    check("sw_take",  32'(trap_take),   1);
    check("sw_cause", 32'(trap_cause),  3);
    check("sw_isint", 32'(trap_is_int), 1);
    clear_inputs();
    tick();
    cmd_mret_ex = 1;
    tick();
    cmd_mret_ex = 0;
    check("sw_mret_state", 32'(dbg_state), 0);

    // ---- timeout: drain_req after 16 ARMED cycles, saturates, falls on exit
    csr_rmie = 1; csr_mtie = 1; frc_cntr_val_leq = 1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("tmo_drain_low", 32'(drain_req), 0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      check("tmo_drain_high", 32'(drain_req), 1);
      check("tmo_no_take",    32'(trap_take), 0);
    end
    cpu_stat_before_exec = 1;
    tick();
    check("tmo_take",  32'(trap_take),   1);
    check("tmo_cause", 32'(trap_cause),  7);
    check("tmo_isint", 32'(trap_is_int), 1);
    clear_inputs();
    tick();
    check("tmo_drain_fall", 32'(drain_req), 0);
    cmd_mret_ex = 1;
    tick();
    cmd_mret_ex = 0;

    // ---- withdrawal: MIE cleared while ARMED
    csr_rmie = 1; csr_meie = 1; g_interrupt = 1;
    tick();
    check("wd_armed", 32'(dbg_state), 1);
    csr_rmie = 0;
    tick();
    check("wd_state", 32'(dbg_state), 0);
    check("wd_take",  32'(trap_take), 0);
    check("wd_drain", 32'(drain_req), 0);
    tick();
    check("wd_take2", 32'(trap_take), 0);
    check("wd_cause_held", 32'(trap_cause), 7);
    clear_inputs();

    // ---- precedence: ecall while ARMED
    csr_rmie = 1; csr_mtie = 1; frc_cntr_val_leq = 1;
    tick();
    check("pre_armed", 32'(dbg_state), 1);
    cmd_ecall_ex = 1;
    tick();
    check("pre_take",  32'(trap_take),   1);
    check("pre_cause", 32'(trap_cause),  11);
    check("pre_isint", 32'(trap_is_int), 0);
    clear_inputs();
    tick();
    check("pre_inh", 32'(in_handler), 1);
    // exception and mret together in HANDLER
    cmd_ebreak_ex = 1; cmd_mret_ex = 1;
    tick();
    clear_inputs();
`ifdef TRAP_DOUBLE_FAULT_EN
    check("df_set",   32'(double_fault), 1);
    check("df_take",  32'(trap_take),    0);
    check("df_state", 32'(dbg_state),    0);
    check("df_cause_held", 32'(trap_cause), 11);
    illegal_ops_ex = 1;
    csr_rmie = 1; csr_meie = 1; g_interrupt = 1;
    tick();
    clear_inputs();
    check("df_ignore_take",  32'(trap_take),    0);
    check("df_ignore_state", 32'(dbg_state),    0);
    check("df_sticky",       32'(double_fault), 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    check("df_reset", 32'(double_fault), 0);
`else
    check("reent_take",  32'(trap_take),   1);
    check("reent_cause", 32'(trap_cause),  3);
    check("reent_isint", 32'(trap_is_int), 0);
    check("reent_df",    32'(double_fault), 0);
    tick();
    check("reent_inh", 32'(in_handler), 1);
    cmd_mret_ex = 1;
    tick();
    cmd_mret_ex = 0;
    check("reent_mret", 32'(dbg_state), 0);
`endif

    // ---- reset while in TAKE
    tick();
    illegal_ops_ex = 1;
    tick();
    illegal_ops_ex = 0;
    check("mid_take", 32'(trap_take), 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    check("mid_rst_take",  32'(trap_take),   0);
    check("mid_rst_inh",   32'(in_handler),  0);
    check("mid_rst_cause", 32'(trap_cause),  0);
    check("mid_rst_state", 32'(dbg_state),   0);
    tick();
    check("mid_after_take", 32'(trap_take),  0);
    check("mid_after_inh",  32'(in_handler), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
